tree_loader: RTL and testbench
==============================

Name: tree_loader

Overview:
- Programs the decision-tree node RAM from a byte stream, so tree contents no longer depend on simulation-time file loading.
- Takes node_count_i nodes, 5 bytes per node, over a valid/ready byte handshake.
- Packs each node into the node-word layout the inference engine consumes and writes it to the RAM write port.
- Rejects malformed trees (bad header byte, non-forward pointers, zero count) and reports an error code.

Parameters:
DATA, 8, width of node threshold and leaf output fields
STATU, 8, width of node address / next-pointer fields
NODE_W, 1+DATA+STATU+STATU+DATA (33), node word width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset; one clock, all state on rising edge
load_start_i  in  1  one-cycle pulse, starts a load when idle or in error
node_count_i  in  STATU  number of nodes N, sampled on accepted load_start_i
byte_i  in  DATA  stream byte
byte_valid_i  in  1  byte_i valid
byte_ready_o  out  1  loader can accept a byte
wr_en_o  out  1  RAM write strobe
wr_addr_o  out  STATU  RAM write address (node index)
wr_data_o  out  NODE_W  {dec, data, next_T, next_F, y}, dec is MSB
busy_o  out  1  load in progress
done_o  out  1  one-cycle pulse, all N nodes written
err_o  out  1  sticky error flag
err_code_o  out  2  00 none, 01 format, 10 pointer, 11 zero count

Behaviour:
- Reset values: all outputs 0; state IDLE; byte and node counters 0.
- States: IDLE, RECV, WRITE, ERR.
- IDLE:
  - load_start_i with node_count_i==0 -> ERR, code 11.
  - load_start_i otherwise -> latch N, clear node_idx and byte_cnt, clear err_o/err_code_o, go to RECV.
- RECV:
  - byte_ready_o=1 and busy_o=1.
  - A byte is accepted only on a cycle with byte_valid_i && byte_ready_o.
  - Accepted bytes are stored by byte_cnt: 0 = header (bit0 = dec, bits 7:1 must be 0), 1 = data, 2 = next_T, 3 = next_F, 4 = y.
  - On accepting byte 4, checks run on the registered fields plus the incoming y:
    - Format: header[7:1] != 0 -> code 01.
    - Pointer (dec==0 only): next_T and next_F must each satisfy node_idx < ptr < N, else code 10.
    - If both fail, format (01) has priority over pointer (10).
    - Leaf nodes (dec==1): pointers are not checked and are written as received.
  - Any check fails -> ERR, no write. All pass -> WRITE.
- WRITE:
  - wr_en_o=1 for exactly one cycle, with wr_addr_o=node_idx and wr_data_o=packed word; byte_ready_o=0.
  - The write occurs 1 cycle after the 5th byte is accepted. Minimum 6 cycles per node.
  - If node_idx==N-1: next cycle done_o=1 for one cycle, busy_o=0, state IDLE.
  - Otherwise: node_idx increments, byte_cnt clears, return to RECV.
- wr_en_o is 0 in every state except WRITE. wr_addr_o/wr_data_o hold their last values otherwise.
- ERR:
  - err_o=1 and err_code_o held; byte_ready_o=0, busy_o=0.
  - Exit only via load_start_i (same handling as IDLE) or reset.
- load_start_i in RECV or WRITE is ignored.
- byte_valid_i outside RECV has no effect; no byte is consumed.
- Forward-pointer rule: node 0 is root and every edge goes to a higher index, so a loaded tree always terminates. The last node must therefore be a leaf.
- Reset mid-load: returns to IDLE immediately with outputs 0. RAM entries already written are left as is. The next load restarts at address 0.
- N is 8 bits, so a load is at most 255 nodes. node_idx never wraps.

Test Plan:
1. Three-node load: N=3, bytes 00 40 01 02 00 | 01 00 00 00 11 | 01 00 00 00 22.
   - Expect writes addr0={0,40,01,02,00}, addr1={1,00,00,00,11}, addr2={1,00,00,00,22}.
   - Expect done_o pulse the cycle after the 3rd write, err_o=0, 15 bytes accepted.
2. Backpressure/gaps: same stream with byte_valid_i low for 1–3 random cycles between bytes.
   - Expect identical writes and done.
   - Expect byte_ready_o=0 during each WRITE cycle, and no byte lost or duplicated.
3. Pointer error: N=3, node0 = 00 40 00 02 00 (next_T=0).
   - Expect no wr_en_o, err_o=1, err_code_o=10, byte_ready_o=0.
   - A following load_start_i with the valid stream from test 1 loads correctly.
4. Format error: N=2, node0 header 03.
   - Expect err_code_o=01, no write.
   - Header 02 with next_T=0 (format and pointer both bad) also gives code 01.
5. Zero count: load_start_i with node_count_i=0.
   - Expect err_o=1, err_code_o=11 the next cycle, byte_ready_o never high.
6. Reset mid-load: N=3, assert reset after 7 accepted bytes (node0 written).
   - Expect all outputs 0 the next cycle.
   - A new load of test 1's stream writes addr0 first and completes with done_o.
   - load_start_i pulsed mid-load in a separate run is ignored (node_idx unchanged).

Source files
------------

// File: rtl/tree_loader.sv
// ----------------------------------------------------------------------------
// tree_loader
//   Fills the decision-tree node RAM from a byte stream. Each node is sent as
//   five bytes: header (bit0 = dec, bits 7:1 must be zero), data, next_T,
//   next_F and y. After the fifth byte is checked, the node is packed into
//   {dec, data, next_T, next_F, y} and written for one cycle.
//
// Ports
//   clk, reset     clock and synchronous active-high reset
//   load_start_i   one-cycle pulse, starts a load (honoured in IDLE or ERR)
//   node_count_i   node count N, sampled together with load_start_i
//   byte_i         stream byte
//   byte_valid_i   byte_i valid; accepted when byte_ready_o is also high
//   byte_ready_o   loader can accept a byte (RECV only)
//   wr_en_o        RAM write strobe (WRITE only)
//   wr_addr_o      RAM write address (node index), held between writes
//   wr_data_o      packed node word, held between writes
//   busy_o         load in progress (RECV or WRITE)
//   done_o         one-cycle pulse after the last node is written
//   err_o          high while in ERR
//   err_code_o     00 none, 01 format, 10 pointer, 11 zero count
// ----------------------------------------------------------------------------
module tree_loader #(
    parameter int DATA   = 8,
    parameter int STATU  = 8,
    parameter int NODE_W = 1 + DATA + STATU + STATU + DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start_i,
    input  logic [STATU-1:0]  node_count_i,
    input  logic [DATA-1:0]   byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [STATU-1:0]  wr_addr_o,
    output logic [NODE_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, ERR} state_t;

    state_t            state_reg, state_next;
    logic [STATU-1:0]  n_reg;
    logic [STATU-1:0]  node_idx_reg;
    logic [2:0]        byte_cnt_reg;
    logic [DATA-1:0]   hdr_reg;
    logic [DATA-1:0]   data_reg;
    logic [STATU-1:0]  next_t_reg;
    logic [STATU-1:0]  next_f_reg;
    logic [1:0]        err_code_reg, err_code_next;
    logic              done_reg;
    logic [STATU-1:0]  wr_addr_reg;
    logic [NODE_W-1:0] wr_data_reg;

    logic accept;
    logic start_load;
    logic fmt_bad;
    logic ptr_bad;
    logic last_node;

    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        accept        = (state_reg == RECV) && byte_valid_i;
        start_load    = load_start_i && ((state_reg == IDLE) || (state_reg == ERR));
        fmt_bad       = (hdr_reg[DATA-1:1] != '0);
        // Forward-pointer rule: decision nodes may only point strictly
        // forward and inside the tree, which guarantees termination.
        ptr_bad       = !hdr_reg[0] &&
                        !((next_t_reg > node_idx_reg) && (next_t_reg < n_reg) &&
                          (next_f_reg > node_idx_reg) && (next_f_reg < n_reg));
        last_node     = (node_idx_reg == n_reg - STATU'(1));

        case (state_reg)
            IDLE, ERR: begin
                if (load_start_i) begin
                    if (node_count_i == '0) begin
                        state_next    = ERR;
                        err_code_next = 2'b11;
                    end else begin
                        state_next    = RECV;
                        err_code_next = 2'b00;
                    end
                end
            end
            RECV: begin
                if (accept && (byte_cnt_reg == 3'd4)) begin
                    // Format error outranks pointer error.
                    if (fmt_bad) begin
                        state_next    = ERR;
                        err_code_next = 2'b01;
                    end else if (ptr_bad) begin
                        state_next    = ERR;
                        err_code_next = 2'b10;
                    end else begin
                        state_next    = WRITE;
                    end
                end
            end
            WRITE: begin
                state_next = last_node ? IDLE : RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            node_idx_reg <= '0;
            byte_cnt_reg <= '0;
            hdr_reg      <= '0;
            data_reg     <= '0;
            next_t_reg   <= '0;
            next_f_reg   <= '0;
            err_code_reg <= '0;
            done_reg     <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
            done_reg     <= (state_reg == WRITE) && last_node;

            if (start_load && (node_count_i != '0)) begin
                n_reg        <= node_count_i;
                node_idx_reg <= '0;
                byte_cnt_reg <= '0;
            end

            if (accept) begin
                case (byte_cnt_reg)
                    3'd0:    hdr_reg    <= byte_i;
                    3'd1:    data_reg   <= byte_i;
                    3'd2:    next_t_reg <= STATU'(byte_i);
                    3'd3:    next_f_reg <= STATU'(byte_i);
                    default: ;
                endcase
                if (byte_cnt_reg != 3'd4) begin
                    byte_cnt_reg <= byte_cnt_reg + 3'd1;
                end
            end

            // The word is packed as the last byte arrives so that the write
            // cycle only has to present registered values.
            if ((state_reg == RECV) && (state_next == WRITE)) begin
                wr_addr_reg <= node_idx_reg;
                wr_data_reg <= {hdr_reg[0], data_reg, next_t_reg, next_f_reg,
                                byte_i};
            end

            if ((state_reg == WRITE) && !last_node) begin
                node_idx_reg <= node_idx_reg + STATU'(1);
                byte_cnt_reg <= '0;
            end
        end
    end

    assign byte_ready_o = (state_reg == RECV);
    assign busy_o       = (state_reg == RECV) || (state_reg == WRITE);
    assign wr_en_o      = (state_reg == WRITE);
    assign wr_addr_o    = wr_addr_reg;
    assign wr_data_o    = wr_data_reg;
    assign done_o       = done_reg;
    assign err_o        = (state_reg == ERR);
    assign err_code_o   = err_code_reg;

endmodule

// File: tb/tb_tree_loader.sv
// ----------------------------------------------------------------------------
// tb_tree_loader
//   Directed and randomized loads of tree_loader. Expected writes and error
//   codes come from a node-by-node reference model over the byte stream.
// ----------------------------------------------------------------------------
module tb_tree_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start_i = 1'b0;
    logic [7:0]  node_count_i = '0;
    logic [7:0]  byte_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [7:0]  wr_addr_o;
    logic [32:0] wr_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    tree_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start_i (load_start_i),
        .node_count_i (node_count_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0]  stream[$];
    logic [7:0]  exp_addr[$];
    logic [32:0] exp_data[$];
    int          exp_code;
    int          exp_bytes;

    int          acc_cyc[$];
    logic [7:0]  got_addr[$];
    logic [32:0] got_data[$];
    int          got_cyc[$];
    int          done_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the bus a little after the falling edge, after the bench drivers.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (byte_valid_i && byte_ready_o) acc_cyc.push_back(cyc);
            if (wr_en_o) begin
                got_addr.push_back(wr_addr_o);
                got_data.push_back(wr_data_o);
                got_cyc.push_back(cyc);
                chk("ready_low_in_write", 64'(byte_ready_o), 64'(0));
            end
            if (done_o) done_cyc.push_back(cyc);
        end
    end

    task automatic clear_mon();
        acc_cyc.delete();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        done_cyc.delete();
    endtask

    // Reference model: walk the nodes in order, stop at the first bad one.
    task automatic model(input int n);
        logic [7:0] h, d, t, f, y;
        exp_addr.delete();
        exp_data.delete();
        exp_code  = 0;
        exp_bytes = 5 * n;
        for (int i = 0; i < n; i++) begin
            h = stream[5*i];   d = stream[5*i+1]; t = stream[5*i+2];
            f = stream[5*i+3]; y = stream[5*i+4];
            if (h[7:1] != 7'd0) begin
                exp_code = 1; exp_bytes = 5 * i + 5; break;
            end
            if (h[0] == 1'b0 &&
                !(int'(t) > i && int'(t) < n && int'(f) > i && int'(f) < n)) begin
                exp_code = 2; exp_bytes = 5 * i + 5; break;
            end
            exp_addr.push_back(8'(i));
            exp_data.push_back({h[0], d, t, f, y});
        end
    endtask

    task automatic gen_tree(input int n, input bit corrupt);
        logic [7:0] h, d, t, f, y;
        int bad;
        bad = int'($urandom_range(0, n - 1));
        stream.delete();
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            y = 8'($urandom);
            if (i == n - 1 || $urandom_range(0, 1) == 1) begin
                h = 8'h01; t = 8'($urandom); f = 8'($urandom);
            end else begin
                h = 8'h00;
                t = 8'($urandom_range(i + 1, n - 1));
                f = 8'($urandom_range(i + 1, n - 1));
            end
            if (corrupt && i == bad) begin
                if ($urandom_range(0, 1) == 1) begin
                    h = h | (8'($urandom_range(1, 127)) << 1);
                end else begin
                    h = 8'h00;
                    t = 8'($urandom_range(0, i));
                end
            end
            stream.push_back(h); stream.push_back(d); stream.push_back(t);
            stream.push_back(f); stream.push_back(y);
        end
    endtask

    task automatic start_load(input int n);
        @(negedge clk);
        load_start_i = 1'b1;
        node_count_i = 8'(n);
        @(negedge clk);
        load_start_i = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        while (byte_ready_o !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("byte_accept", 64'(byte_ready_o), 64'(1));
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input bit gaps);
        for (int i = from; i < to; i++) begin
            send_byte(stream[i]);
            if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic finish_check();
        int k;
        k = 0;
        while (done_cyc.size() == 0 && err_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("settle", 64'(k < 20), 64'(1));
        chk("write_count", 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int j = 0; j < got_addr.size() && j < exp_addr.size(); j++) begin
            chk("wr_addr", 64'(got_addr[j]), 64'(exp_addr[j]));
            chk("wr_data", 64'(got_data[j]), 64'(exp_data[j]));
            if (5 * j + 4 < acc_cyc.size())
                chk("wr_latency", 64'(got_cyc[j]), 64'(acc_cyc[5*j+4] + 1));
        end
        chk("done_count", 64'(done_cyc.size()), 64'(exp_code == 0 ? 1 : 0));
        if (done_cyc.size() == 1 && got_cyc.size() > 0)
            chk("done_timing", 64'(done_cyc[0]), 64'(got_cyc[got_cyc.size()-1] + 1));
        chk("bytes_accepted", 64'(acc_cyc.size()), 64'(exp_bytes));
        chk("err_o", 64'(err_o), 64'(exp_code != 0));
        chk("err_code", 64'(err_code_o), 64'(exp_code));
        chk("busy_idle", 64'(busy_o), 64'(0));
        chk("ready_idle", 64'(byte_ready_o), 64'(0));
    endtask

    task automatic run_load(input int n, input bit gaps);
        model(n);
        clear_mon();
        start_load(n);
        send_range(0, exp_bytes, gaps);
        finish_check();
    endtask

    task automatic set_t1_stream();
        stream = '{8'h00, 8'h40, 8'h01, 8'h02, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'h11,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'h22};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] w0;
        w0 = {1'b0, 8'h40, 8'h01, 8'h02, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(byte_ready_o), 64'(0));
        chk("rst_wr_en", 64'(wr_en_o), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr_o), 64'(0));
        chk("rst_wr_data", 64'(wr_data_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_err_code", 64'(err_code_o), 64'(0));
        reset = 1'b0;

        // Three-node load, back to back
        set_t1_stream();
        run_load(3, 1'b0);
        if (got_data.size() > 0) chk("t1_word0", 64'(got_data[0]), 64'(w0));
        $display("load t1: writes=%0d done=%0d", got_addr.size(), done_cyc.size());

        // Same stream with gaps between bytes
        run_load(3, 1'b1);
        $display("load t2 gaps: writes=%0d done=%0d", got_addr.size(), done_cyc.size());

        // Pointer error, then recovery with a valid stream
        stream = '{8'h00, 8'h40, 8'h00, 8'h02, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'h11,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'h22};
        run_load(3, 1'b0);
        chk("t3_code_10", 64'(err_code_o), 64'(2'b10));
        $display("load t3 pointer: err=%0d code=%0d", err_o, err_code_o);
        set_t1_stream();
        run_load(3, 1'b0);
        $display("load t3 recover: writes=%0d done=%0d", got_addr.size(), done_cyc.size());

        // Format error, alone and combined with a pointer error
        stream = '{8'h03, 8'h40, 8'h01, 8'h01, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'h11};
        run_load(2, 1'b0);
        chk("t4_code_01", 64'(err_code_o), 64'(2'b01));
        stream = '{8'h02, 8'h40, 8'h00, 8'h01, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h00, 8'h11};
        run_load(2, 1'b0);
        chk("t4_prio_01", 64'(err_code_o), 64'(2'b01));
        $display("load t4 format: err=%0d code=%0d", err_o, err_code_o);

        // Zero node count
        clear_mon();
        @(negedge clk);
        load_start_i = 1'b1;
        node_count_i = 8'd0;
        byte_i = 8'h55;
        byte_valid_i = 1'b1;
        @(negedge clk);
        load_start_i = 1'b0;
        chk("t5_err", 64'(err_o), 64'(1));
        chk("t5_code", 64'(err_code_o), 64'(2'b11));
        repeat (3) @(negedge clk);
        chk("t5_ready", 64'(byte_ready_o), 64'(0));
        byte_valid_i = 1'b0;
        chk("t5_no_bytes", 64'(acc_cyc.size()), 64'(0));
        $display("load t5 zero count: err=%0d code=%0d", err_o, err_code_o);

        // Reset in the middle of a load
        set_t1_stream();
        model(3);
        clear_mon();
        start_load(3);
        send_range(0, 7, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ready", 64'(byte_ready_o), 64'(0));
        chk("t6_wr_en", 64'(wr_en_o), 64'(0));
        chk("t6_wr_addr", 64'(wr_addr_o), 64'(0));
        chk("t6_wr_data", 64'(wr_data_o), 64'(0));
        chk("t6_busy", 64'(busy_o), 64'(0));
        chk("t6_err", 64'(err_o), 64'(0));
        chk("t6_code", 64'(err_code_o), 64'(0));
        chk("t6_pre_writes", 64'(got_addr.size()), 64'(1));
        reset = 1'b0;
        run_load(3, 1'b0);
        if (got_addr.size() > 0) chk("t6_first_addr", 64'(got_addr[0]), 64'(0));
        $display("load t6 after reset: writes=%0d done=%0d", got_addr.size(), done_cyc.size());

        // load_start_i during WRITE and during RECV is ignored
        model(3);
        clear_mon();
        start_load(3);
        send_range(0, 5, 1'b0);
        load_start_i = 1'b1;
        node_count_i = 8'd1;
        @(negedge clk);
        load_start_i = 1'b0;
        send_range(5, 7, 1'b0);
        load_start_i = 1'b1;
        @(negedge clk);
        load_start_i = 1'b0;
        send_range(7, 15, 1'b0);
        finish_check();
        $display("load t6 start ignored: writes=%0d done=%0d", got_addr.size(), done_cyc.size());

        // Randomized trees, some corrupted
        for (int r = 0; r < 25; r++) begin
            int n;
            bit corrupt;
            n = int'($urandom_range(1, 8));
            corrupt = ($urandom_range(0, 3) == 0);
            gen_tree(n, corrupt);
            run_load(n, 1'($urandom_range(0, 1)));
            $display("load rand %0d: n=%0d writes=%0d exp_code=%0d code=%0d",
                     r, n, got_addr.size(), exp_code, err_code_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
